// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: requester-side and serializer-side signals of spi_req_arbiter.
// master is the arbiter's view, slave is the environment's (requesters plus serializer).
interface spi_req_arbiter_if #(parameter int NUM_REQ = 4, parameter int DATA_W = 16);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic [NUM_REQ-1:0]         err;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] cur_id;
    logic [NUM_REQ-1:0]         spi_sel;
    logic [DATA_W-1:0]          spi_word;
    logic                       spi_start;
    logic                       spi_busy;
    logic                       spi_done;
    modport master (
        input  req, req_data, spi_busy, spi_done,
        output gnt, done, err, busy, cur_id, spi_sel, spi_word, spi_start
    );
    modport slave (
        output req, req_data, spi_busy, spi_done,
        input  gnt, done, err, busy, cur_id, spi_sel, spi_word, spi_start
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one SPI serializer among NUM_REQ requesters with a chip-select gap.
// Round-robin by default; define SPI_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority.
module spi_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input logic clk,
    input logic reset,
    spi_req_arbiter_if.master bus
);
    localparam int IDW   = $clog2(NUM_REQ);
    localparam int GAP_N = GAP_CYC < 1 ? 1 : GAP_CYC;
    localparam int TMAX  = TIMEOUT_CYC > GAP_N ? TIMEOUT_CYC : GAP_N;
    localparam int TW    = $clog2(TMAX + 1);
    localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, GAP = 2'd3;

    logic [1:0]     state;
    logic [TW-1:0]  timer;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW:0]   idx;
    logic           found;

`ifdef SPI_ARB_FIXED_PRI_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            ptr <= '0;
        else if (state == IDLE && found)
            ptr <= win == IDW'(NUM_REQ - 1) ? '0 : win + 1'b1;
`endif

    // Scan downward in offset so the request closest to ptr is the last one written.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(NUM_REQ))
                idx = idx - (IDW + 1)'(NUM_REQ);
            if (bus.req[idx[IDW-1:0]]) begin
                win   = idx[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            timer         <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= '0;
            bus.busy      <= 1'b0;
            bus.cur_id    <= '0;
            bus.spi_sel   <= '0;
            bus.spi_word  <= '0;
            bus.spi_start <= 1'b0;
        end else begin
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.err       <= '0;
            bus.spi_start <= 1'b0;
            case (state)
                IDLE:
                    if (found) begin
                        bus.gnt      <= NUM_REQ'(1) << win;
                        bus.spi_sel  <= NUM_REQ'(1) << win;
                        bus.spi_word <= bus.req_data[int'(win) * DATA_W +: DATA_W];
                        bus.cur_id   <= win;
                        bus.busy     <= 1'b1;
                        state        <= LAUNCH;
                    end
                LAUNCH:
                    if (!bus.spi_busy) begin
                        bus.spi_start <= 1'b1;
                        timer         <= '0;
                        state         <= WAIT;
                    end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // A done landing on the timeout cycle takes precedence over err.
                    if (bus.spi_done || timer == TW'(TIMEOUT_CYC - 1)) begin
                        bus.done    <= bus.spi_done ? NUM_REQ'(1) << bus.cur_id : '0;
                        bus.err     <= bus.spi_done ? '0 : NUM_REQ'(1) << bus.cur_id;
                        bus.spi_sel <= '0;
                        timer       <= '0;
                        state       <= GAP;
                    end
                end
                GAP:
                    if (timer == TW'(GAP_N - 1)) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else
                        timer <= timer + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: scoreboard bench for spi_req_arbiter in its default round-robin build.
module tb_spi_req_arbiter;
    localparam int N = 4, W = 16, TO = 64;
    typedef struct { logic [3:0] g; logic [1:0] id; logic [15:0] w; } gexp_t;
    typedef struct { logic [3:0] d; logic [3:0] e; } rexp_t;

    logic clk = 1'b0, reset = 1'b0;
    int n_cmp = 0, n_bad = 0, n_start = 0, k, s0;
    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t ge;
    rexp_t re;
    logic [15:0] words [4] = '{16'h2563, 16'h6A61, 16'hA265, 16'h7564};
    logic [3:0] oh;

    spi_req_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
    spi_req_arbiter #(.NUM_REQ(N), .DATA_W(W), .GAP_CYC(2), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: grants and completions are matched against what the stimulus queued.
    always @(negedge clk) if (reset) begin
        if (bus.spi_start) n_start++;
        if (|bus.gnt) begin
            if (gq.size() == 0) check("gnt_unexpected", bus.gnt, 0);
            else begin
                ge = gq.pop_front();
                check("gnt", bus.gnt, ge.g);
                check("gnt_sel", bus.spi_sel, ge.g);
                check("gnt_word", bus.spi_word, ge.w);
                check("gnt_id", bus.cur_id, ge.id);
                check("gnt_busy", bus.busy, 1);
            end
        end
        if (|bus.done || |bus.err) begin
            if (rq.size() == 0) check("res_unexpected", {bus.done, bus.err}, 0);
            else begin
                re = rq.pop_front();
                check("res_done", bus.done, re.d);
                check("res_err", bus.err, re.e);
                check("res_sel", bus.spi_sel, 0);
            end
        end
    end

    task automatic wait_gnt();
        int i = 0;
        while (!(|bus.gnt) && i < 300) begin @(negedge clk); i++; end
        if (!(|bus.gnt)) check("wait_gnt_timeout", 0, 1);
    endtask

    task automatic wait_start();
        int i = 0;
        while (!bus.spi_start && i < 300) begin @(negedge clk); i++; end
        if (!bus.spi_start) check("wait_start_timeout", 0, 1);
    endtask

    task automatic wait_res();
        int i = 0;
        while (!(|bus.done || |bus.err) && i < 300) begin @(negedge clk); i++; end
        if (!(|bus.done || |bus.err)) check("wait_res_timeout", 0, 1);
    endtask

    task automatic pulse_done();
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
    endtask

    task automatic frame(input int dly);
        wait_start();
        repeat (dly) @(negedge clk);
        pulse_done();
        wait_res();
    endtask

    initial begin
        bus.req = '0; bus.req_data = '0; bus.spi_busy = 1'b0; bus.spi_done = 1'b0;
        for (int i = 0; i < 4; i++) bus.req_data[i*W +: W] = words[i];
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_done_err", {bus.done, bus.err}, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cur_id", bus.cur_id, 0);
        check("rst_sel", bus.spi_sel, 0);
        check("rst_word", bus.spi_word, 0);
        check("rst_start", bus.spi_start, 0);
        reset = 1'b1;
        @(negedge clk);

        // Round-robin with all four requests held.
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << (i % 4);
            gq.push_back('{oh, 2'(i % 4), words[i % 4]});
            rq.push_back('{oh, 4'b0000});
        end
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_gnt();
            if (i == 4) bus.req = '0;
            frame(4);
        end
        repeat (4) @(negedge clk);

        // Single request, done 16 cycles after start, then the gap.
        bus.req_data[1*W +: W] = 16'hA569;
        gq.push_back('{4'b0010, 2'd1, 16'hA569});
        rq.push_back('{4'b0010, 4'b0000});
        bus.req = 4'b0010;
        wait_gnt();
        s0 = n_start;
        bus.req = '0;
        @(negedge clk);
        check("single_start_latency", bus.spi_start, 1);
        repeat (16) @(negedge clk);
        pulse_done();
        wait_res();
        check("single_one_start", n_start - s0, 1);
        @(negedge clk);
        check("gap_sel", bus.spi_sel, 0);
        check("gap_busy", bus.busy, 1);
        @(negedge clk);
        check("gap_end_busy", bus.busy, 0);
        repeat (2) @(negedge clk);

        // Serializer busy after grant stalls the launch.
        gq.push_back('{4'b0001, 2'd0, words[0]});
        rq.push_back('{4'b0001, 4'b0000});
        bus.req = 4'b0001;
        wait_gnt();
        bus.req = '0;
        bus.spi_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_start", bus.spi_start, 0);
            check("stall_sel", bus.spi_sel, 4'b0001);
            check("stall_err", bus.err, 0);
        end
        bus.spi_busy = 1'b0;
        @(negedge clk);
        check("stall_release_start", bus.spi_start, 1);
        repeat (3) @(negedge clk);
        pulse_done();
        wait_res();
        repeat (4) @(negedge clk);

        // Timeout on requester 2, then the next grant right after the gap.
        bus.req_data[2*W +: W] = 16'h1234;
        gq.push_back('{4'b0100, 2'd2, 16'h1234});
        rq.push_back('{4'b0000, 4'b0100});
        bus.req = 4'b0100;
        wait_gnt();
        bus.req = '0;
        wait_start();
        k = 0;
        while (!(|bus.err || |bus.done) && k < 100) begin @(negedge clk); k++; end
        check("timeout_latency", k, TO);
        gq.push_back('{4'b1000, 2'd3, words[3]});
        rq.push_back('{4'b1000, 4'b0000});
        bus.req = 4'b1000;
        k = 0;
        while (!(|bus.gnt) && k < 20) begin @(negedge clk); k++; end
        check("gap_to_grant", k, 3);
        bus.req = '0;
        frame(5);
        repeat (4) @(negedge clk);

        // spi_done on the timeout cycle: done wins.
        gq.push_back('{4'b0001, 2'd0, words[0]});
        rq.push_back('{4'b0001, 4'b0000});
        bus.req = 4'b0001;
        wait_gnt();
        bus.req = '0;
        wait_start();
        repeat (TO - 1) @(negedge clk);
        pulse_done();
        @(negedge clk);
        check("collision_no_err", bus.err, 0);
        repeat (3) @(negedge clk);

        // Reset during WAIT, then the pointer must be back at 0.
        gq.push_back('{4'b0010, 2'd1, 16'hA569});
        bus.req = 4'b0010;
        wait_gnt();
        bus.req = '0;
        wait_start();
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_sel", bus.spi_sel, 0);
        check("arst_start", bus.spi_start, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_cur_id", bus.cur_id, 0);
        check("arst_word", bus.spi_word, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        gq.push_back('{4'b0001, 2'd0, words[0]});
        rq.push_back('{4'b0001, 4'b0000});
        bus.req = 4'b1001;
        wait_gnt();
        bus.req = '0;
        frame(4);
        repeat (5) @(negedge clk);

        check("gq_drained", gq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares one 16-bit SPI serializer (chip-select, sclk and MOSI engine) among NUM_REQ requesters.
- Arbitrates between pending requests and captures the winner's word.
- Drives the winner's one-hot chip-select and launches the serializer with a start/done handshake.
- Reports completion or timeout per requester, and enforces a chip-select gap between frames.

Parameters:
- NUM_REQ, 4, number of requesters and one-hot select lines (2..8).
- DATA_W, 16, width of one SPI frame word.
- GAP_CYC, 2, idle cycles with all selects low between frames (minimum effective 1).
- TIMEOUT_CYC, 64, cycles allowed in WAIT for spi_done before abort (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held until gnt.
- req_data  in  NUM_REQ*DATA_W  word i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse; the word is captured in this cycle.
- done  out  NUM_REQ  one-hot, 1-cycle pulse when the frame completes.
- err  out  NUM_REQ  one-hot, 1-cycle pulse on timeout.
- busy  out  1  high from grant through end of GAP.
- cur_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- spi_sel  out  NUM_REQ  one-hot chip-select enable to the serializer; active-high, all zero when not in a frame.
- spi_word  out  DATA_W  captured word, stable from grant until the next grant.
- spi_start  out  1  1-cycle launch pulse to the serializer.
- spi_busy  in  1  serializer is shifting; no start is allowed while high.
- spi_done  in  1  1-cycle pulse at the end of the serializer frame.

Behaviour:
- All outputs are registered. Reset (async assert, sync deassert) gives:
  - state IDLE;
  - gnt, done, err, spi_sel, spi_start = 0;
  - busy = 0, cur_id = 0, spi_word = 0;
  - round-robin pointer = 0, timer = 0.
- FSM states: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any req bit is set at edge N, choose the winner w: first set bit searching from pointer upward, wrapping modulo NUM_REQ.
  - At edge N: gnt[w]=1 for one cycle, spi_word<=req_data[w], spi_sel<=onehot(w), cur_id<=w, busy<=1, pointer<=(w+1) mod NUM_REQ. Go to LAUNCH.
  - No request: stay in IDLE.
- LAUNCH:
  - If spi_busy is low at an edge, spi_start pulses for one cycle, the timer clears, and the FSM goes to WAIT.
  - If spi_busy is high, hold in LAUNCH with spi_sel held and no timeout.
- WAIT:
  - Timer increments each cycle.
  - spi_done=1: done[cur_id] pulses, spi_sel<=0, go to GAP.
  - Otherwise, when timer==TIMEOUT_CYC-1: err[cur_id] pulses, spi_sel<=0, go to GAP.
  - spi_done in the same cycle as timeout: done wins and err stays 0.
- GAP:
  - Count max(GAP_CYC,1) cycles with spi_sel=0, then busy<=0 and go to IDLE.
  - The next grant can occur on the edge that leaves GAP+IDLE, so the minimum frame-to-frame spacing is GAP+1 cycles.
- Handshake edge cases:
  - spi_done outside WAIT is ignored.
  - req deasserted before gnt means the request is withdrawn silently.
  - req still high after gnt is treated as a new request.
  - Requests arriving outside IDLE wait; there is no queueing beyond the req level.
- Latency: req sampled at edge N gives gnt/spi_sel in cycle N+1 and spi_start in cycle N+2, if spi_busy is low.
- Reset mid-frame: spi_sel and spi_start drop immediately. No done or err is emitted for the aborted frame.
- Exactly one of done/err is produced per gnt unless reset intervenes.

Optional Feature:
- SPI_ARB_FIXED_PRI_EN defined:
  - Fixed priority; the lowest set req index always wins.
  - The pointer register is removed.
  - Starvation of high indices is accepted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single request: after reset, req=4'b0010, req_data[1]=16'hA569, spi_done 16 cycles after start.
  - gnt=4'b0010 one cycle, spi_sel=4'b0010, spi_word=16'hA569.
  - One spi_start, then done=4'b0010, spi_sel=0 for 2 cycles, busy falls.
- Round-robin: req=4'b1111 held, words 16'h2563/16'h6A61/16'hA265/16'h7564.
  - Grant order is 0,1,2,3,0; each spi_word matches its requester.
- Busy stall: spi_busy=1 for 10 cycles after grant.
  - spi_start is not asserted until spi_busy=0.
  - spi_sel is held and no err is raised.
- Timeout: grant requester 2 and never pulse spi_done.
  - err=4'b0100 exactly TIMEOUT_CYC=64 cycles after spi_start; done stays 0.
  - The next request is granted after the gap.
- Done/timeout collision: spi_done arrives on the timeout cycle.
  - done pulses, err stays 0.
- Reset mid-WAIT: assert reset during WAIT.
  - All outputs return to reset values asynchronously.
  - After release, req=4'b0001 is granted normally, with the pointer at 0.
